// File: rtl/nand_seq_pkg.sv
// Shared definitions for the bit-serial NAND sequencer.
//   - OP_* : request operation encodings (req_op)
//   - src_e: micro-op operand sources fed to the NAND gate
//   - dst_e: micro-op destination for the sampled gate output
//   - state_e: controller FSM states
package nand_seq_pkg;

    localparam logic [1:0] OP_NAND = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_OR   = 2'd2;
    localparam logic [1:0] OP_XOR  = 2'd3;

    localparam int MAX_STEPS = 4;
    localparam int STEP_W    = 2;

    typedef enum logic [2:0] {
        SRC_A,
        SRC_B,
        SRC_T1,
        SRC_T2,
        SRC_T3
    } src_e;

    typedef enum logic [1:0] {
        DST_T1,
        DST_T2,
        DST_T3,
        DST_R
    } dst_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/nand_seq_ucode.sv
// Micro-program ROM: maps (op, step) to the NAND operand sources, the
// destination of the sampled result and whether this is the last step
// of the bit.
//   op        in  2  operation (OP_*)
//   step      in  2  micro-step index within the current bit
//   src_x     out    source driven on gate input a
//   src_y     out    source driven on gate input b
//   dest      out    where the gate output is stored
//   last_step out 1  final micro-step for this bit
module nand_seq_ucode
    import nand_seq_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [STEP_W-1:0] step,
    output src_e              src_x,
    output src_e              src_y,
    output dst_e              dest,
    output logic              last_step
);

    always_comb begin
        // Default is the single NAND step (A,B -> R)
        src_x     = SRC_A;
        src_y     = SRC_B;
        dest      = DST_R;
        last_step = 1'b1;
        case (op)
            OP_AND: begin
                case (step)
                    2'd0: begin
                        dest      = DST_T1;
                        last_step = 1'b0;
                    end
                    default: begin
                        src_x = SRC_T1;
                        src_y = SRC_T1;
                    end
                endcase
            end
            OP_OR: begin
                case (step)
                    2'd0: begin
                        src_y     = SRC_A;
                        dest      = DST_T1;
                        last_step = 1'b0;
                    end
                    2'd1: begin
                        src_x     = SRC_B;
                        dest      = DST_T2;
                        last_step = 1'b0;
                    end
                    default: begin
                        src_x = SRC_T1;
                        src_y = SRC_T2;
                    end
                endcase
            end
            OP_XOR: begin
                case (step)
                    2'd0: begin
                        dest      = DST_T1;
                        last_step = 1'b0;
                    end
                    2'd1: begin
                        src_y     = SRC_T1;
                        dest      = DST_T2;
                        last_step = 1'b0;
                    end
                    2'd2: begin
                        src_x     = SRC_B;
                        src_y     = SRC_T1;
                        dest      = DST_T3;
                        last_step = 1'b0;
                    end
                    default: begin
                        src_x = SRC_T2;
                        src_y = SRC_T3;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nand_seq.sv
// Bit-serial sequencer that time-multiplexes one external NAND gate to
// compute NAND/AND/OR/XOR over WIDTH-bit operands, LSB first.
//   clk, rst_n             clock, async active-low reset
//   req_valid/ready/op/a/b request handshake and operands
//   rsp_valid/ready/data   result handshake
//   gate_a, gate_b         registered NAND inputs
//   gate_q                 NAND output, sampled after SETTLE cycles
module nand_seq
    import nand_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_q
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [BW-1:0] LAST_BIT    = BW'(WIDTH - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

    state_e             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_res;
    logic [BW-1:0]      r_bit;
    logic [STEP_W-1:0]  r_step;
    logic [SW-1:0]      r_settle;
    logic               r_t1, r_t2, r_t3;
    dst_e               r_dest;
    logic               r_last;
    logic               r_req_ready, r_rsp_valid, r_gate_a, r_gate_b;
    logic [WIDTH-1:0]   r_rsp_data;

    logic               w_hit;
    logic               w_t1, w_t2, w_t3;
    logic [WIDTH-1:0]   w_res;
    logic [1:0]         w_nop;
    logic [STEP_W-1:0]  w_nstep;
    logic [BW-1:0]      w_nbit;
    logic               w_abit, w_bbit;
    src_e               w_src_x, w_src_y;
    dst_e               w_ndest;
    logic               w_nlast;
    logic               w_ga, w_gb;

    function automatic logic f_src(src_e s, logic a, logic b,
                                   logic t1, logic t2, logic t3);
        case (s)
            SRC_A:   return a;
            SRC_B:   return b;
            SRC_T1:  return t1;
            SRC_T2:  return t2;
            SRC_T3:  return t3;
            default: return 1'b0;
        endcase
    endfunction

    // The ROM always describes the micro-op that will be loaded into the
    // gate registers on the next sampling (or accept) edge.
    nand_seq_ucode u_ucode (
        .op        (w_nop),
        .step      (w_nstep),
        .src_x     (w_src_x),
        .src_y     (w_src_y),
        .dest      (w_ndest),
        .last_step (w_nlast)
    );

    // Values after the current sample lands; the next micro-op may read
    // the temp being written this edge, so it is bypassed here.
    always_comb begin
        w_hit = (r_settle == LAST_SETTLE);
        w_t1  = (r_dest == DST_T1) ? gate_q : r_t1;
        w_t2  = (r_dest == DST_T2) ? gate_q : r_t2;
        w_t3  = (r_dest == DST_T3) ? gate_q : r_t3;
        w_res = r_res;
        if (r_dest == DST_R) w_res[r_bit] = gate_q;

        w_nop   = r_op;
        w_nstep = '0;
        w_nbit  = r_bit;
        w_abit  = 1'b0;
        w_bbit  = 1'b0;
        if (r_state == IDLE) begin
            w_nop  = req_op;
            w_abit = req_a[0];
            w_bbit = req_b[0];
        end else begin
            if (r_last) begin
                if (r_bit != LAST_BIT) w_nbit = r_bit + 1'b1;
            end else begin
                w_nstep = r_step + 1'b1;
            end
            w_abit = r_a[w_nbit];
            w_bbit = r_b[w_nbit];
        end
    end

    assign w_ga = f_src(w_src_x, w_abit, w_bbit, w_t1, w_t2, w_t3);
    assign w_gb = f_src(w_src_y, w_abit, w_bbit, w_t1, w_t2, w_t3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_bit       <= '0;
            r_step      <= '0;
            r_settle    <= '0;
            r_t1        <= 1'b0;
            r_t2        <= 1'b0;
            r_t3        <= 1'b0;
            r_dest      <= DST_T1;
            r_last      <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_gate_a    <= 1'b0;
            r_gate_b    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gate_a <= 1'b0;
                    r_gate_b <= 1'b0;
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_bit       <= '0;
                        r_step      <= '0;
                        r_settle    <= '0;
                        r_dest      <= w_ndest;
                        r_last      <= w_nlast;
                        r_gate_a    <= w_ga;
                        r_gate_b    <= w_gb;
                        r_req_ready <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_hit) begin
                        r_settle <= '0;
                        r_t1     <= w_t1;
                        r_t2     <= w_t2;
                        r_t3     <= w_t3;
                        r_res    <= w_res;
                        if (r_last && (r_bit == LAST_BIT)) begin
                            r_rsp_data  <= w_res;
                            r_rsp_valid <= 1'b1;
                            r_gate_a    <= 1'b0;
                            r_gate_b    <= 1'b0;
                            r_state     <= DONE;
                        end else begin
                            r_bit    <= w_nbit;
                            r_step   <= w_nstep;
                            r_dest   <= w_ndest;
                            r_last   <= w_nlast;
                            r_gate_a <= w_ga;
                            r_gate_b <= w_gb;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign gate_a    = r_gate_a;
    assign gate_b    = r_gate_b;

endmodule

// File: tb/tb_nand_seq.sv
// Bench for nand_seq: NAND gate modelled inline, scoreboard plus monitor.
module tb_nand_seq;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a, req_b, rsp_data;
    logic             gate_a, gate_b, gate_q;

    logic             req3_valid, req3_ready, rsp3_valid, rsp3_ready;
    logic [1:0]       req3_op;
    logic [WIDTH-1:0] req3_a, req3_b, rsp3_data;
    logic             gate_a3, gate_b3, gate_q3;

    assign gate_q  = ~(gate_a & gate_b);
    assign gate_q3 = ~(gate_a3 & gate_b3);

    nand_seq #(.WIDTH(WIDTH), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .gate_a(gate_a), .gate_b(gate_b), .gate_q(gate_q)
    );

    nand_seq #(.WIDTH(WIDTH), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req3_valid), .req_ready(req3_ready), .req_op(req3_op),
        .req_a(req3_a), .req_b(req3_b),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_data(rsp3_data),
        .gate_a(gate_a3), .gate_b(gate_b3), .gate_q(gate_q3)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rnd_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the operation as plain arithmetic; latency from the
    // per-op NAND step count (NAND 1, AND 2, OR 3, XOR 4).
    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return ~(a & b);
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input int settle);
        return WIDTH * (int'(op) + 1) * settle;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output int acc);
        int   n;
        logic rdy;
        exp_t e;
        n = 0;
        rdy = 1'b0;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        forever begin
            if (rnd_bp) rsp_ready = ($urandom_range(0, 2) != 0);
            rdy = req_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
            if (rdy) break;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept expected accept within 500 cycles");
                break;
            end
        end
        acc = cyc;
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_a = WIDTH'($urandom);
        req_b = WIDTH'($urandom);
        if (rdy) begin
            e.data = ref_op(op, a, b);
            e.acc = acc;
            e.lat = ref_lat(op, 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (!(sb.size() == 0 && !rsp_valid && req_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: pops and compares when a response handshake is about to occur
    initial begin
        logic             pv;
        logic [WIDTH-1:0] pd;
        int               rise;
        exp_t             e;
        pv = 1'b0;
        pd = '0;
        rise = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (!req_ready && !rsp_valid)
                chk("gate_q_known", 32'($isunknown(gate_q)), 32'd0);
            if (rsp_valid) begin
                if (!pv) rise = cyc;
                else chk("rsp_data_stable", 32'(rsp_data), 32'(pd));
                chk("req_ready_in_done", 32'(req_ready), 32'd0);
                pd = rsp_data;
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got %0h expected no response", rsp_data);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_data", 32'(rsp_data), 32'(e.data));
                        chk("latency", 32'(rise - e.acc), 32'(e.lat));
                    end
                end
            end
            pv = rsp_valid && !rsp_ready;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int               acc, acc2, r, n;
        logic [1:0]       gab;
        logic [1:0]       op;
        logic [WIDTH-1:0] a, b;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        req3_valid = 1'b0; req3_op = '0; req3_a = '0; req3_b = '0; rsp3_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_gates", 32'({gate_a, gate_b}), 32'd0);
        chk("rst3_req_ready", 32'(req3_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations, one at a time
        send(2'd0, 8'hFF, 8'h0F, acc); drain();
        send(2'd1, 8'hF0, 8'h3C, acc); drain();
        send(2'd2, 8'h00, 8'h81, acc); drain();
        send(2'd3, 8'hA5, 8'h3C, acc); drain();

        // Back-pressure on an XOR result with a competing request pending
        rsp_ready = 1'b0;
        send(2'd3, 8'hA5, 8'h3C, acc);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        req_valid = 1'b1; req_op = 2'd1; req_a = 8'hFF; req_b = 8'h55;
        repeat (10) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        r = cyc;
        send(2'd1, 8'hFF, 8'h55, acc2);
        chk("bp_accept_cycle", 32'(acc2 - r), 32'd2);
        drain();

        // Reset in the middle of an XOR
        send(2'd3, 8'h5A, 8'hC3, acc);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_gates", 32'({gate_a, gate_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'd1, 8'hFF, 8'h55, acc);
        drain();

        // Randomized traffic with random consumer stalls
        rnd_bp = 1'b1;
        repeat (25) begin
            op = 2'($urandom);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            send(op, a, b, acc);
        end
        rnd_bp = 1'b0;
        drain();

        // SETTLE=3 instance: XOR 0x0F ^ 0xFF
        @(negedge clk);
        req3_valid = 1'b1; req3_op = 2'd3; req3_a = 8'h0F; req3_b = 8'hFF;
        chk("s3_ready", 32'(req3_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req3_valid = 1'b0; req3_a = 8'h00; req3_b = 8'h00;
        gab = {gate_a3, gate_b3};
        for (int i = 1; i <= 96; i++) begin
            @(negedge clk);
            if (i < 96) begin
                chk("s3_rsp_early", 32'(rsp3_valid), 32'd0);
                if (i % 3 != 0) chk("s3_gate_const", 32'({gate_a3, gate_b3}), 32'(gab));
                else gab = {gate_a3, gate_b3};
            end else begin
                chk("s3_rsp_valid", 32'(rsp3_valid), 32'd1);
                chk("s3_rsp_data", 32'(rsp3_data), 32'(ref_op(2'd3, 8'h0F, 8'hFF)));
            end
        end
        @(negedge clk);
        chk("s3_rsp_cleared", 32'(rsp3_valid), 32'd0);
        chk("s3_data_hold", 32'(rsp3_data), 32'(ref_op(2'd3, 8'h0F, 8'hFF)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nand_seq.md
Name: nand_seq

Overview:
- Bit-serial sequencer that shares a single external nand00 gate instance to compute NAND/AND/OR/XOR over WIDTH-bit operands.
- Time-multiplexes the gate using a micro-program of NAND steps per bit, and buffers the result behind a valid/ready response handshake.
- Sits between a requester (test harness or microcode front end) and the physical/modelled NAND gate. It is the first clocked controller for the gate-level primitives.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- SETTLE, 1, clock cycles each micro-op holds gate inputs before sampling gate_q (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  operation: 0=NAND, 1=AND, 2=OR, 3=XOR.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  result.
- gate_a  out  1  drives nand00 input a.
- gate_b  out  1  drives nand00 input b.
- gate_q  in  1  nand00 output q.

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, gate_a=0, gate_b=0; all counters and scratch registers cleared. Reset mid-operation aborts the operation and discards its result; no partial rsp_valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch op, A, B; bit=0, step=0, settle=0; go to RUN.
  - gate_a/gate_b held 0 while idle.
- RUN:
  - req_ready=0.
  - gate_a/gate_b are registered, selected from {A[bit], B[bit], t1, t2, t3} per the micro-program.
  - settle counts 0..SETTLE-1. On the edge where settle==SETTLE-1, gate_q is sampled into the step's destination (t1/t2/t3 or result[bit]), settle resets, and step advances.
- Micro-programs (src_x, src_y -> dest):
  - NAND: (A,B->R).
  - AND: (A,B->t1), (t1,t1->R).
  - OR: (A,A->t1), (B,B->t2), (t1,t2->R).
  - XOR: (A,B->t1), (A,t1->t2), (B,t1->t3), (t2,t3->R).
  - STEPS(op) = 1/2/3/4.
- After the last step of a bit: bit increments, step=0. After the last step of bit WIDTH-1: go to DONE.
- Bit order is LSB first; result bits are written in place.
- Latency: rsp_valid is high in the cycle following edge number WIDTH*STEPS(op)*SETTLE after the accept edge.
- DONE:
  - rsp_valid=1 and rsp_data is stable until rsp_valid&&rsp_ready. On that edge: rsp_valid=0, back to IDLE.
  - rsp_data holds its value afterwards until the next result.
  - No new request is accepted in DONE (req_ready=0), so there is no same-cycle response/accept overlap.
- req_* inputs are ignored outside the accept edge. Changing operands mid-run has no effect.
- gate_q is sampled as-is; no X detection in RTL. The bench checks for X.

Decomposition:
- Package nand_seq_pkg:
  - op encodings OP_NAND/OP_AND/OP_OR/OP_XOR;
  - source enum SRC_A, SRC_B, SRC_T1, SRC_T2, SRC_T3;
  - dest enum DST_T1, DST_T2, DST_T3, DST_R;
  - state enum IDLE/RUN/DONE;
  - MAX_STEPS=4.
- Sub-module nand_seq_ucode: combinational ROM mapping (op, step) -> src_x, src_y, dest, last_step.

Test Plan (bench wires gate_a/gate_b/gate_q to a real nand00; WIDTH=8):
- SETTLE=1, NAND a=0xFF b=0x0F -> rsp_data=0xF0, rsp_valid 8 cycles after accept.
- SETTLE=1, AND 0xF0&0x3C -> 0x30 after 16 cycles; OR 0x00|0x81 -> 0x81 after 24 cycles.
- SETTLE=1, XOR 0xA5^0x3C -> 0x99 after 32 cycles; gate_q never X during RUN.
- Back-pressure: hold rsp_ready=0 for 10 cycles after XOR completes -> rsp_valid and rsp_data stable, req_ready=0, a second req_valid is not accepted; accepted on the first cycle after the rsp handshake.
- Reset mid-op: assert rst_n=0 at cycle 5 of an XOR -> req_ready=1, rsp_valid=0, gate_a=gate_b=0 immediately. A subsequent AND 0xFF&0x55 -> 0x55.
- SETTLE=3, XOR 0x0F^0xFF -> 0xF0 after 96 cycles; gate inputs constant within each 3-cycle micro-op.
